// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors, Baud_Set decode, FSM states and parity modes.
// The receiver and transmitter both import this so their timing always agrees.
package uart_pkg;

    localparam int DIV_W = 13;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_t;

    // Terminal count of the bit divider: one line bit lasts (result + 1) clocks.
    function automatic logic [DIV_W-1:0] bps_dr_calc(input int baud, input int clk_ns);
        return DIV_W'(1_000_000_000 / baud / clk_ns - 1);
    endfunction

    localparam logic [DIV_W-1:0] BPS_DR_9600   = bps_dr_calc(9600, 20);
    localparam logic [DIV_W-1:0] BPS_DR_19200  = bps_dr_calc(19200, 20);
    localparam logic [DIV_W-1:0] BPS_DR_38400  = bps_dr_calc(38400, 20);
    localparam logic [DIV_W-1:0] BPS_DR_57600  = bps_dr_calc(57600, 20);
    localparam logic [DIV_W-1:0] BPS_DR_115200 = bps_dr_calc(115200, 20);

    // Codes 5-7 fall back to 9600 so an out-of-range setting still yields a usable line.
    function automatic logic [DIV_W-1:0] baud_decode(input logic [2:0] baud_set, input int clk_ns);
        case (baud_set)
            3'd1:    return bps_dr_calc(19200, clk_ns);
            3'd2:    return bps_dr_calc(38400, clk_ns);
            3'd3:    return bps_dr_calc(57600, clk_ns);
            3'd4:    return bps_dr_calc(115200, clk_ns);
            default: return bps_dr_calc(9600, clk_ns);
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Enable-gated bit-period divider: bit_end marks the last clock of each period.
// Held at zero while disabled so every enabled run starts on a fresh period.
module uart_baud_cnt
    import uart_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             en,
    input  logic [DIV_W-1:0] Bps_DR,
    output logic             bit_end
);

    logic [DIV_W-1:0] div_cnt_reg;

    always_ff @(posedge Clk) begin
        if (Reset || !en) begin
            div_cnt_reg <= '0;
        end else if (div_cnt_reg == Bps_DR) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    assign bit_end = en && (div_cnt_reg == Bps_DR);

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: one accepted Send_En produces one start/8-data/[parity]/stop frame.
// The line is registered from the current state, so it trails the FSM by one clock.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int PARITY        = PARITY_NONE,
    parameter int CLK_PERIOD_NS = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] Baud_Set,
    input  logic [7:0] Data,
    input  logic       Send_En,
    output logic       uart_tx,
    output logic       Tx_Busy,
    output logic       Tx_Done
);

    uart_state_t      state_reg, state_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       data_reg;
    logic [DIV_W-1:0] bps_dr_reg;
    logic             tx_reg, tx_next;
    logic             done_reg, done_next;
    logic             bit_end;
    logic             accept;
    logic             parity_bit;
    logic [DIV_W-1:0] dr_table [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dr_table
            assign dr_table[gi] = baud_decode(3'(gi), CLK_PERIOD_NS);
        end
    endgenerate

    assign accept     = Send_En && (state_reg == ST_IDLE);
    assign parity_bit = (PARITY == PARITY_ODD) ? ~^data_reg : ^data_reg;

    uart_baud_cnt u_baud_cnt (
        .Clk     (Clk),
        .Reset   (Reset),
        .en      (state_reg != ST_IDLE),
        .Bps_DR  (bps_dr_reg),
        .bit_end (bit_end)
    );

    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        tx_next      = 1'b1;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                bit_idx_next = '0;
                if (accept) state_next = ST_START;
            end
            ST_START: begin
                tx_next = 1'b0;
                if (bit_end) state_next = ST_DATA;
            end
            ST_DATA: begin
                tx_next = data_reg[bit_idx_reg];
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            ST_PAR: begin
                tx_next = parity_bit;
                if (bit_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
            data_reg    <= '0;
            bps_dr_reg  <= BPS_DR_9600;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
            tx_reg      <= tx_next;
            done_reg    <= done_next;
            // Frame parameters are frozen here; input changes mid-frame are ignored.
            if (accept) begin
                data_reg   <= Data;
                bps_dr_reg <= dr_table[Baud_Set];
            end
        end
    end

    assign uart_tx = tx_reg;
    assign Tx_Done = done_reg;
    assign Tx_Busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: three instances (no/odd/even parity) share clock, reset and data.
// Frames are compared bit-by-bit on every clock against hand-written frame vectors.
module tb_uart_byte_tx;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] Baud_Set = 3'd0;
    logic [7:0] Data = 8'h00;
    logic       send_en [3];
    logic       tx_line [3];
    logic       tx_busy [3];
    logic       tx_done [3];

    int checks = 0;
    int errors = 0;

    always #10 Clk = ~Clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            uart_byte_tx #(
                .PARITY        (gi),
                .CLK_PERIOD_NS (20)
            ) u_dut (
                .Clk      (Clk),
                .Reset    (Reset),
                .Baud_Set (Baud_Set),
                .Data     (Data),
                .Send_En  (send_en[gi]),
                .uart_tx  (tx_line[gi]),
                .Tx_Busy  (tx_busy[gi]),
                .Tx_Done  (tx_done[gi])
            );
        end
    endgenerate

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses Send_En for one edge (acceptance edge N), then scrambles Data/Baud_Set.
    task automatic start_send(input int inst, input logic [7:0] d, input logic [2:0] baud, input string tag);
        Data          = d;
        Baud_Set      = baud;
        send_en[inst] = 1'b1;
        tick(1);
        send_en[inst] = 1'b0;
        Data          = ~d;
        Baud_Set      = 3'd7;
        $display("frame %s inst=%0d data=%02h baud_set=%0d", tag, inst, d, baud);
        chk($sformatf("%s_busy_after_accept", tag), 32'(tx_busy[inst]), 32'd1);
        chk($sformatf("%s_line_high_after_accept", tag), 32'(tx_line[inst]), 32'd1);
        chk($sformatf("%s_done_low_after_accept", tag), 32'(tx_done[inst]), 32'd0);
    endtask

    // Called just after edge N; line bit k must hold on edges N+1+k*b .. N+(k+1)*b.
    task automatic check_frame(input int inst, input logic [10:0] bits, input int nbits,
                               input int b, input bit full, input string tag, input int inj_c);
        logic [10:0] bad = '0;
        bit busy_bad = 1'b0;
        bit done_bad = 1'b0;
        for (int c = 1; c <= nbits * b; c++) begin
            if (c == inj_c) begin
                Data          = 8'h34;
                Baud_Set      = 3'd0;
                send_en[inst] = 1'b1;
            end
            tick(1);
            send_en[inst] = 1'b0;
            if (tx_line[inst] !== bits[(c - 1) / b]) bad[(c - 1) / b] = 1'b1;
            if (c < nbits * b || !full) begin
                if (tx_busy[inst] !== 1'b1) busy_bad = 1'b1;
                if (tx_done[inst] !== 1'b0) done_bad = 1'b1;
            end
        end
        for (int k = 0; k < nbits; k++) begin
            chk($sformatf("%s_bit%0d_level", tag, k), 32'(bad[k]), 32'd0);
        end
        chk($sformatf("%s_busy_in_frame", tag), 32'(busy_bad), 32'd0);
        chk($sformatf("%s_no_early_done", tag), 32'(done_bad), 32'd0);
        if (full) begin
            chk($sformatf("%s_done_at_end", tag), 32'(tx_done[inst]), 32'd1);
            chk($sformatf("%s_busy_low_at_end", tag), 32'(tx_busy[inst]), 32'd0);
            chk($sformatf("%s_line_high_at_end", tag), 32'(tx_line[inst]), 32'd1);
        end
    endtask

    initial begin
        bit idle_bad;
        for (int i = 0; i < 3; i++) send_en[i] = 1'b0;

        Reset = 1'b1;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_line_%0d", i), 32'(tx_line[i]), 32'd1);
            chk($sformatf("reset_busy_%0d", i), 32'(tx_busy[i]), 32'd0);
            chk($sformatf("reset_done_%0d", i), 32'(tx_done[i]), 32'd0);
        end
        Reset = 1'b0;
        tick(2);

        // 0x55 at 115200 baud: 434-clock bits, done 4340 edges after acceptance.
        start_send(0, 8'h55, 3'd4, "b55");
        check_frame(0, {1'b1, 8'h55, 1'b0}, 10, 434, 1'b1, "b55", 0);
        tick(5);

        // 0x07 has three ones: odd parity bit 0, even parity bit 1.
        start_send(1, 8'h07, 3'd4, "odd07");
        check_frame(1, 11'b1_0_00000111_0, 11, 434, 1'b1, "odd07", 0);
        tick(5);
        start_send(2, 8'h07, 3'd4, "even07");
        check_frame(2, 11'b1_1_00000111_0, 11, 434, 1'b1, "even07", 0);
        tick(5);

        // Mid-frame request with new Data/Baud_Set is ignored; the next one right after done is taken.
        start_send(0, 8'h12, 3'd4, "rej12");
        check_frame(0, {1'b1, 8'h12, 1'b0}, 10, 434, 1'b1, "rej12", 1000);
        start_send(0, 8'h34, 3'd4, "b2b34");
        check_frame(0, {1'b1, 8'h34, 1'b0}, 10, 434, 1'b1, "b2b34", 0);
        tick(5);

        // Abort during D3 of 0xA3 (line is low there), then confirm the line stays idle.
        start_send(0, 8'hA3, 3'd4, "abortA3");
        check_frame(0, {1'b1, 8'hA3, 1'b0}, 4, 434, 1'b0, "abortA3", 0);
        tick(100);
        Reset = 1'b1;
        tick(1);
        chk("abort_line_high", 32'(tx_line[0]), 32'd1);
        chk("abort_busy_low", 32'(tx_busy[0]), 32'd0);
        chk("abort_done_low", 32'(tx_done[0]), 32'd0);
        Reset = 1'b0;
        idle_bad = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            tick(1);
            if (tx_line[0] !== 1'b1 || tx_done[0] !== 1'b0 || tx_busy[0] !== 1'b0) idle_bad = 1'b1;
        end
        chk("abort_stays_idle", 32'(idle_bad), 32'd0);

        start_send(0, 8'hC3, 3'd4, "afterC3");
        check_frame(0, {1'b1, 8'hC3, 1'b0}, 10, 434, 1'b1, "afterC3", 0);
        tick(5);

        // Baud_Set 6 decodes as 9600: 5208-clock bits (start and D0 checked).
        start_send(0, 8'h01, 3'd6, "baud6");
        check_frame(0, {1'b1, 8'h01, 1'b0}, 2, 5208, 1'b0, "baud6", 0);
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        tick(5);

        // 57600 baud full frame: 868-clock bits.
        start_send(0, 8'hA3, 3'd3, "b57600");
        check_frame(0, {1'b1, 8'hA3, 1'b0}, 10, 868, 1'b1, "b57600", 0);
        tick(1);
        chk("b57600_done_one_cycle", 32'(tx_done[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Serial UART transmitter: serialises one 8-bit byte per request into an 8N1 frame (optional parity) on the `uart_tx` line at one of five selectable baud rates. It is the transmit-side counterpart of the UART byte receiver and shares its 50 MHz (20 ns) clock, `Baud_Set` encoding and frame format. Upstream logic issues a single-cycle `Send_En` with `Data`. The block reports `Tx_Busy` while a frame is on the line and pulses `Tx_Done` when the stop bit completes.

## Interface
- `PARITY`, default 0: 0 = none (10-bit frame), 1 = odd, 2 = even (11-bit frame, parity bit between D7 and stop).
- `CLK_PERIOD_NS`, default 20: clock period used for the divisor constants.
- `Clk`  input  1  system clock; all logic on rising edge.
- `Reset`  input  1  reset is synchronous and active-high.
- `Baud_Set`  input  3  0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200, 5–7 = 9600.
- `Data`  input  8  byte to send; sampled only on an accepted `Send_En`.
- `Send_En`  input  1  request; accepted only when `Tx_Busy` = 0.
- `uart_tx`  output  1  serial line; idle high; registered.
- `Tx_Busy`  output  1  high from the cycle after acceptance until the frame ends.
- `Tx_Done`  output  1  one-cycle pulse at frame end; registered.

## Operation
- **Divisor:** `Bps_DR = 10^9 / baud / CLK_PERIOD_NS − 1`. Values are 5207, 2603, 1301, 867, 433. Counter `div_cnt` is 13 bits, counts 0..`Bps_DR`, and wraps to 0.
- **Bit counter:** `bit_end = (div_cnt == Bps_DR)`. Each line bit lasts exactly `Bps_DR + 1` clocks.
- **Latching on accept:** `Baud_Set` and `Data` are latched on acceptance. Changes mid-frame have no effect.
- **FSM states:**
  - `IDLE`: `uart_tx` = 1, `div_cnt` = 0.
  - `START`: `uart_tx` = 0.
  - `DATA`: LSB first; `bit_idx` runs 0..7.
  - `PAR`: only when `PARITY` ≠ 0. Odd parity is `~^data_r`; even parity is `^data_r`.
  - `STOP`: `uart_tx` = 1.
- **FSM transitions:**
  - `IDLE` → `START` on `Send_En` & !`Tx_Busy`.
  - `START` → `DATA` on `bit_end`.
  - `DATA` → `DATA` on `bit_end` while `bit_idx` < 7; `bit_idx` increments.
  - `DATA` → `PAR` or `STOP` on `bit_end` when `bit_idx` = 7.
  - `PAR` → `STOP` on `bit_end`.
  - `STOP` → `IDLE` on `bit_end`, asserting `Tx_Done` on the same edge.
- **Busy and requests:** `Tx_Busy` = (state ≠ `IDLE`). `Send_En` while busy is ignored: no queueing, no error flag.
- **Back-to-back:** `Send_En` in the cycle after the `Tx_Done` pulse (state already `IDLE`) is accepted. No extra idle bits are inserted beyond the stop bit.
- **Reset values:** `uart_tx` = 1, `Tx_Busy` = 0, `Tx_Done` = 0, state = `IDLE`, `div_cnt` = 0, `bit_idx` = 0.
- **Reset mid-frame:** a reset asserted mid-frame aborts it. `uart_tx` is high on the edge after `Reset` is sampled, and no `Tx_Done` is generated.

## Timing
- **Start latency:** `Send_En` sampled high at edge N puts `uart_tx` low after edge N+1, since `uart_tx` is registered from the state. Line bit k occupies edges N+1+k·(`Bps_DR`+1) through N+(k+1)·(`Bps_DR`+1).
- **Frame length:** 10·(`Bps_DR`+1) clocks with no parity; 11·(`Bps_DR`+1) with parity. At 115200 baud that is 4340 / 4774 clocks.
- **Done pulse:** `Tx_Done` is high for exactly one cycle, the cycle after the final stop-bit clock.
- **Busy timing:** `Tx_Busy` falls in the same cycle `Tx_Done` is high.
- **Glitch-free output:** `uart_tx` changes only at bit boundaries; there are no intra-bit glitches.

## Structure
- **Shared package `uart_pkg`:**
  - baud divisor constants `BPS_DR_9600` … `BPS_DR_115200`;
  - `Baud_Set` decode function;
  - FSM state enum;
  - parity-mode constants.
- Keep everything in this package so that receiver and transmitter agree on one source.
- **Sub-module `uart_baud_cnt`:** enable-gated divider. Inputs are `Clk`, `Reset`, `en` and `Bps_DR`; output is `bit_end`; it clears to 0 when `en` = 0. It is reusable by the receiver at 16× with a different divisor.
- **`uart_byte_tx` itself:** holds the latch registers, FSM, shift/bit index, parity and output registers.

## Test plan
- **Single byte, no parity:** `Baud_Set` = 4, `Data` = 0x55, one-cycle `Send_En` → `uart_tx` shows 0,1,0,1,0,1,0,1,0,1; each level lasts 434 clocks. `Tx_Done` pulses once, 4340 clocks after the start bit begins; `Tx_Busy` is high throughout.
- **Loopback:** transmitter drives the receiver at `Baud_Set` 0–4, `Data` = 0xA3, 0x00, 0xFF → received `Data` matches and receiver `Rx_Done` fires once per byte; `Baud_Set` = 6 behaves as 9600 (bit = 5208 clocks).
- **Parity:** `PARITY` = 1, `Data` = 0x07 → parity bit = 0 (odd: 3 ones + 0 keeps the count odd). `PARITY` = 2, `Data` = 0x07 → parity bit = 1. Frame is 11 bits.
- **Busy rejection and back-to-back:**
  - `Send_En` with 0x12, then `Send_En` with 0x34 mid-frame → only 0x12 is sent.
  - `Send_En` with 0x34 in the cycle after `Tx_Done` → stop bit is followed immediately by a start bit, with no extra idle.
- **Mid-frame changes and reset:**
  - Change `Data`/`Baud_Set` during a frame → frame is unchanged.
  - Assert `Reset` at D3 → `uart_tx` = 1 and `Tx_Busy` = 0 the next cycle, no `Tx_Done`.
  - Subsequent send of 0xC3 → correct frame.
